// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage
//   Instruction-fetch stage: owns the PC register, issues instruction-memory
//   requests and fills the IF/ID pipeline register. A one-entry skid buffer
//   holds a word that the memory returned while the hazard unit was stalling.
//   That word is replayed into IF/ID when the stall releases.
//
// Ports
//   clk            : single clock, rising edge
//   rst_n          : asynchronous active-low reset
//   next_pc        : PC chosen by the upstream increment/jump selector
//   stall          : hazard unit holds PC and IF/ID
//   flush          : taken jump/branch, discards the fetched instruction
//   imem_rdata     : instruction word, valid when imem_ready=1
//   imem_ready     : memory returns data for imem_addr this cycle
//   pc             : current PC register
//   pc_plus1       : pc+1 modulo 2048 (selector increment input)
//   imem_addr      : instruction memory address (equals pc)
//   imem_req       : fetch request
//   ifid_instr     : IF/ID instruction register
//   ifid_pc_plus1  : IF/ID copy of pc+1 for the captured instruction
//   ifid_valid     : IF/ID holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
  parameter logic [10:0] RESET_PC = 11'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] next_pc,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [10:0] pc,
  output logic [10:0] pc_plus1,
  output logic [10:0] imem_addr,
  output logic        imem_req,
  output logic [31:0] ifid_instr,
  output logic [10:0] ifid_pc_plus1,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [10:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [10:0] ifpc1_q, ifpc1_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [10:0] skid_pc1_q, skid_pc1_d;
  logic [10:0] pc_inc;

  // 11-bit add wraps 0x7FF -> 0x000 naturally
  assign pc_inc = pc_q + 11'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        BOOT:    state_d = FETCH;
        FETCH:   if (stall && imem_ready) state_d = HOLD;
        HOLD:    if (!stall) state_d = FETCH;
        default: state_d = BOOT;
      endcase
    end
  end

  // Output logic: requests only go out in FETCH
  always_comb begin
    imem_req = (state_q == FETCH);
  end

  // Datapath next-state. ifid_instr / ifid_pc_plus1 keep their old contents
  // whenever a bubble is inserted; only the valid bit marks it.
  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    ifpc1_d      = ifpc1_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc1_d   = skid_pc1_q;
    if (flush) begin
      pc_d         = next_pc;
      valid_d      = 1'b0;
      skid_instr_d = 32'h0;
      skid_pc1_d   = 11'h0;
    end else begin
      case (state_q)
        FETCH: begin
          if (!stall) begin
            if (imem_ready) begin
              instr_d = imem_rdata;
              ifpc1_d = pc_inc;
              valid_d = 1'b1;
              pc_d    = next_pc;
            end else begin
              valid_d = 1'b0;
            end
          end else if (imem_ready) begin
            // Word arrived during a stall: park it until the stall drops
            skid_instr_d = imem_rdata;
            skid_pc1_d   = pc_inc;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d = skid_instr_q;
            ifpc1_d = skid_pc1_q;
            valid_d = 1'b1;
            pc_d    = next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      ifpc1_q      <= 11'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc1_q   <= 11'h0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      ifpc1_q      <= ifpc1_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc1_q   <= skid_pc1_d;
    end
  end

  assign pc            = pc_q;
  assign pc_plus1      = pc_inc;
  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus1 = ifpc1_q;
  assign ifid_valid    = valid_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] next_pc;
  logic        stall;
  logic        flush;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [10:0] pc;
  logic [10:0] pc_plus1;
  logic [10:0] imem_addr;
  logic        imem_req;
  logic [31:0] ifid_instr;
  logic [10:0] ifid_pc_plus1;
  logic        ifid_valid;

  logic        use_jump;
  logic [10:0] jump_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Memory model: word = 0xA0000000 + address; selector = pc+1 or jump
  assign imem_rdata = 32'hA000_0000 + {21'b0, imem_addr};
  assign next_pc    = use_jump ? jump_pc : pc_plus1;

  pc_fetch_stage #(.RESET_PC(11'h000)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .stall(stall), .flush(flush),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc), .pc_plus1(pc_plus1),
    .imem_addr(imem_addr), .imem_req(imem_req), .ifid_instr(ifid_instr),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b1;
    use_jump = 1'b0; jump_pc = 11'h0;
    tick(); tick();
    checks++; if (pc !== 11'h000) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, 11'h000); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", ifid_instr); end
    checks++; if (ifid_pc_plus1 !== 11'h0) begin errors++; $display("FAIL rst_ifpc1 got %h exp 0", ifid_pc_plus1); end
    checks++; if (pc_plus1 !== 11'h001) begin errors++; $display("FAIL rst_pcp1 got %h exp 001", pc_plus1); end
  endtask

  task automatic test_boot_stream;
    rst_n = 1'b1;
    tick();  // edge 1: BOOT -> FETCH
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_req1 got %b exp 1", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL boot_valid1 got %b exp 0", ifid_valid); end
    checks++; if (pc !== 11'h000) begin errors++; $display("FAIL boot_pc1 got %h exp 000", pc); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (ifid_instr !== 32'hA000_0000 + k) begin errors++; $display("FAIL stream_instr%0d got %h exp %h", k, ifid_instr, 32'hA000_0000 + k); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b exp 1", k, ifid_valid); end
      checks++; if (ifid_pc_plus1 !== 11'(k + 1)) begin errors++; $display("FAIL stream_ifpc1_%0d got %h exp %h", k, ifid_pc_plus1, 11'(k + 1)); end
      checks++; if (pc !== 11'(k + 1)) begin errors++; $display("FAIL stream_pc%0d got %h exp %h", k, pc, 11'(k + 1)); end
    end
  endtask

  task automatic test_stall_hold;
    // pc = 5, IF/ID holds word 4
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d got %b exp 0", k, imem_req); end
      checks++; if (pc !== 11'h005) begin errors++; $display("FAIL hold_pc%0d got %h exp 005", k, pc); end
      checks++; if (ifid_instr !== 32'hA000_0004) begin errors++; $display("FAIL hold_instr%0d got %h exp A0000004", k, ifid_instr); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d got %b exp 1", k, ifid_valid); end
    end
    stall = 1'b0;
    tick();
    checks++; if (ifid_instr !== 32'hA000_0005) begin errors++; $display("FAIL release_instr got %h exp A0000005", ifid_instr); end
    checks++; if (ifid_pc_plus1 !== 11'h006) begin errors++; $display("FAIL release_ifpc1 got %h exp 006", ifid_pc_plus1); end
    checks++; if (pc !== 11'h006) begin errors++; $display("FAIL release_pc got %h exp 006", pc); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got %b exp 1", imem_req); end
  endtask

  task automatic test_flush_in_hold;
    // pc = 6: stall into HOLD with word 6 buffered, then flush to 0x120
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fh_req_hold got %b exp 0", imem_req); end
    flush = 1'b1; use_jump = 1'b1; jump_pc = 11'h120;
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL fh_valid got %b exp 0", ifid_valid); end
    checks++; if (pc !== 11'h120) begin errors++; $display("FAIL fh_pc got %h exp 120", pc); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fh_req got %b exp 1", imem_req); end
    checks++; if (ifid_instr !== 32'hA000_0005) begin errors++; $display("FAIL fh_instr_kept got %h exp A0000005", ifid_instr); end
    flush = 1'b0; stall = 1'b0; use_jump = 1'b0;
    tick();
    checks++; if (ifid_instr !== 32'hA000_0120) begin errors++; $display("FAIL fh_next_instr got %h exp A0000120", ifid_instr); end
    checks++; if (ifid_pc_plus1 !== 11'h121) begin errors++; $display("FAIL fh_next_ifpc1 got %h exp 121", ifid_pc_plus1); end
    checks++; if (pc !== 11'h121) begin errors++; $display("FAIL fh_next_pc got %h exp 121", pc); end
  endtask

  task automatic test_not_ready;
    // pc = 0x121, IF/ID = word 0x120
    imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL nr_valid%0d got %b exp 0", k, ifid_valid); end
      checks++; if (pc !== 11'h121) begin errors++; $display("FAIL nr_pc%0d got %h exp 121", k, pc); end
      checks++; if (ifid_instr !== 32'hA000_0120) begin errors++; $display("FAIL nr_instr%0d got %h exp A0000120", k, ifid_instr); end
    end
    // stall with no data: stays in FETCH, nothing moves
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL nrs_req got %b exp 1", imem_req); end
    checks++; if (pc !== 11'h121) begin errors++; $display("FAIL nrs_pc got %h exp 121", pc); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL nrs_valid got %b exp 0", ifid_valid); end
    stall = 1'b0; imem_ready = 1'b1;
    tick();
    checks++; if (ifid_instr !== 32'hA000_0121) begin errors++; $display("FAIL nr_resume_instr got %h exp A0000121", ifid_instr); end
    checks++; if (pc !== 11'h122) begin errors++; $display("FAIL nr_resume_pc got %h exp 122", pc); end
  endtask

  task automatic test_wrap;
    use_jump = 1'b1; jump_pc = 11'h7FF;
    tick();
    checks++; if (pc !== 11'h7FF) begin errors++; $display("FAIL wrap_pc got %h exp 7FF", pc); end
    checks++; if (pc_plus1 !== 11'h000) begin errors++; $display("FAIL wrap_pcp1 got %h exp 000", pc_plus1); end
    use_jump = 1'b0;
    tick();
    checks++; if (ifid_instr !== 32'hA000_07FF) begin errors++; $display("FAIL wrap_instr got %h exp A00007FF", ifid_instr); end
    checks++; if (ifid_pc_plus1 !== 11'h000) begin errors++; $display("FAIL wrap_ifpc1 got %h exp 000", ifid_pc_plus1); end
    checks++; if (pc !== 11'h000) begin errors++; $display("FAIL wrap_pc_next got %h exp 000", pc); end
  endtask

  task automatic test_reset_mid_hold;
    stall = 1'b1;
    tick();  // now in HOLD with a buffered word
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmh_in_hold got %b exp 0", imem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 11'h000) begin errors++; $display("FAIL rmh_pc got %h exp 000", pc); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rmh_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rmh_instr got %h exp 0", ifid_instr); end
    checks++; if (ifid_pc_plus1 !== 11'h0) begin errors++; $display("FAIL rmh_ifpc1 got %h exp 0", ifid_pc_plus1); end
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmh_req1 got %b exp 1", imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rmh_valid1 got %b exp 0", ifid_valid); end
    tick();
    checks++; if (ifid_instr !== 32'hA000_0000) begin errors++; $display("FAIL rmh_instr2 got %h exp A0000000", ifid_instr); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL rmh_valid2 got %b exp 1", ifid_valid); end
    checks++; if (pc !== 11'h001) begin errors++; $display("FAIL rmh_pc2 got %h exp 001", pc); end
  endtask

  initial begin
    test_reset();
    test_boot_stream();
    test_stall_hold();
    test_flush_in_hold();
    test_not_ready();
    test_wrap();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
